// File: rtl/axis_arb_pkg.sv
// Shared definitions for the pair-sum engine arbiter: state encodings,
// default widths and the ceiling-log2 helper used to size selects and pointers.
package axis_arb_pkg;

  localparam int DEF_TDATA_W      = 32;
  localparam int DEF_NUM_SRC      = 4;
  localparam int DEF_MAX_IN_WORDS = 8;
  localparam int DEF_TAG_DEPTH    = 4;

  typedef enum logic {
    ARB = 1'b0,
    FWD = 1'b1
  } arb_state_t;

  // Ceiling log2, never below 1 so single-bit selects stay legal.
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axis_tag_fifo.sv
// Synchronous FIFO of source tags, one entry per packet in flight through the
// engine. Pointers carry one extra wrap bit to tell full from empty.
module axis_tag_fifo
  import axis_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = DEF_TAG_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = clogb2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/axis_pair_sum_arbiter.sv
// Round-robin sharing of one pair-sum engine between NUM_SRC stream sources;
// results are routed back with TDEST taken from a FIFO of granted source tags.
module axis_pair_sum_arbiter
  import axis_arb_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = DEF_TDATA_W,
  parameter int NUM_SRC          = DEF_NUM_SRC,
  parameter int MAX_IN_WORDS     = DEF_MAX_IN_WORDS,
  parameter int TAG_DEPTH        = DEF_TAG_DEPTH
) (
  input  logic                                AXIS_ACLK,
  input  logic                                AXIS_ARESET,
  input  logic [NUM_SRC*AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC-1:0]                  S_AXIS_TVALID,
  input  logic [NUM_SRC-1:0]                  S_AXIS_TLAST,
  output logic [NUM_SRC-1:0]                  S_AXIS_TREADY,
  output logic [AXIS_TDATA_WIDTH-1:0]         E_M_AXIS_TDATA,
  output logic                                E_M_AXIS_TVALID,
  output logic                                E_M_AXIS_TLAST,
  input  logic                                E_M_AXIS_TREADY,
  input  logic [AXIS_TDATA_WIDTH-1:0]         E_S_AXIS_TDATA,
  input  logic                                E_S_AXIS_TVALID,
  input  logic                                E_S_AXIS_TLAST,
  output logic                                E_S_AXIS_TREADY,
  output logic [AXIS_TDATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic                                M_AXIS_TVALID,
  output logic                                M_AXIS_TLAST,
  output logic [clogb2(NUM_SRC)-1:0]          M_AXIS_TDEST,
  input  logic                                M_AXIS_TREADY,
  output logic [AXIS_TDATA_WIDTH/8-1:0]       M_AXIS_TKEEP,
  output logic                                ERR_ORPHAN
);

  localparam int SEL_W = clogb2(NUM_SRC);
  localparam int CNT_W = clogb2(MAX_IN_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_IN_WORDS - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] w_rr_ptr_nxt;
  logic [SEL_W-1:0] r_grant;
  logic [SEL_W-1:0] w_grant_nxt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_beat_cnt_nxt;
  logic             r_err_orphan;

  logic             w_fwd;
  logic             w_fwd_hs;
  logic             w_pick_found;
  logic [SEL_W-1:0] w_pick_idx;
  logic [SEL_W-1:0] w_cand;
  logic             w_push;
  logic             w_pop;
  logic             w_tag_vld;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [SEL_W-1:0] w_fifo_head;

  // Cyclic search for the first requesting source at or after rr_ptr.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = r_rr_ptr;
    w_cand       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_cand = r_rr_ptr + SEL_W'(i);
      if (!w_pick_found && S_AXIS_TVALID[w_cand]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_cand;
      end
    end
  end

  assign w_fwd           = (r_state == FWD) & ~AXIS_ARESET;
  assign E_M_AXIS_TDATA  = S_AXIS_TDATA[int'(r_grant)*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
  assign E_M_AXIS_TVALID = w_fwd & S_AXIS_TVALID[r_grant];
  assign E_M_AXIS_TLAST  = S_AXIS_TLAST[r_grant] | (r_beat_cnt == LAST_BEAT);
  assign w_fwd_hs        = E_M_AXIS_TVALID & E_M_AXIS_TREADY;

  always_comb begin
    S_AXIS_TREADY = '0;
    if (w_fwd) S_AXIS_TREADY[r_grant] = E_M_AXIS_TREADY;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_grant_nxt    = r_grant;
    w_beat_cnt_nxt = r_beat_cnt;
    w_push         = 1'b0;
    case (r_state)
      ARB: begin
        if (w_pick_found && !w_fifo_full) begin
          w_grant_nxt = w_pick_idx;
          w_push      = 1'b1;
          w_state_nxt = FWD;
        end
      end
      FWD: begin
        if (w_fwd_hs) begin
          // Forced TLAST at MAX_IN_WORDS splits long packets; the tail re-arbitrates.
          if (E_M_AXIS_TLAST) begin
            w_rr_ptr_nxt   = r_grant + 1'b1;
            w_beat_cnt_nxt = '0;
            w_state_nxt    = ARB;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      r_state      <= ARB;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_beat_cnt   <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      if (E_S_AXIS_TVALID && w_fifo_empty) r_err_orphan <= 1'b1;
    end
  end

  // Result path: combinational pass-through, held off until a tag is owed.
  assign w_tag_vld       = ~w_fifo_empty & ~AXIS_ARESET;
  assign M_AXIS_TDATA    = E_S_AXIS_TDATA;
  assign M_AXIS_TLAST    = E_S_AXIS_TLAST;
  assign M_AXIS_TVALID   = E_S_AXIS_TVALID & w_tag_vld;
  assign E_S_AXIS_TREADY = M_AXIS_TREADY & w_tag_vld;
  assign M_AXIS_TDEST    = w_fifo_head;
  assign M_AXIS_TKEEP    = '1;
  assign ERR_ORPHAN      = r_err_orphan;
  assign w_pop           = M_AXIS_TVALID & M_AXIS_TREADY & E_S_AXIS_TLAST;

  axis_tag_fifo #(
    .WIDTH (SEL_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .i_clk   (AXIS_ACLK),
    .i_rst   (AXIS_ARESET),
    .i_push  (w_push),
    .i_din   (w_grant_nxt),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule
